// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART byte transmitter among NUM_REQ requesters,
// keeps multi-byte messages contiguous and watches the transmitter busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         tx_clk,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         grant_active,
    output logic                         timeout_err,
    output logic [15:0]                  byte_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   lock_id_q, lock_id_d;
    logic            lock_q, lock_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            tout_q, tout_d;
    logic [15:0]     byte_count_q, byte_count_d;
    logic [IW-1:0]   idx, winner, sel;
    logic            found, fire;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        idx    = '0;
        winner = rr_q;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign sel = lock_q ? lock_id_q : winner;

    always_comb begin
        req_ready = '0;
        if (!RST && state_q == IDLE && (lock_q ? req_valid[lock_id_q] : found))
            req_ready[sel] = 1'b1;
    end

    assign fire = |req_ready;

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        grant_d      = grant_q;
        rr_d         = rr_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        wd_d         = wd_q;
        tout_d       = 1'b0;
        byte_count_d = byte_count_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d    = WAIT_BUSY;
                    tx_data_d  = req_data[{sel, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    grant_d    = sel;
                    rr_d       = sel;
                    lock_d     = !req_last[sel];
                    lock_id_d  = sel;
                    wd_d       = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_q == WW'(BUSY_TIMEOUT - 2)) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                    lock_d  = 1'b0;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d      = IDLE;
                    byte_count_d = byte_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (RST) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            grant_q      <= '0;
            rr_q         <= IW'(NUM_REQ - 1);
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wd_q         <= '0;
            tout_q       <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            wd_q         <= wd_d;
            tout_q       <= tout_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign grant_id     = grant_q;
    assign grant_active = (state_q != IDLE) || lock_q;
    assign timeout_err  = tout_q;
    assign byte_count   = byte_count_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter among NUM_REQ requesters. It accepts bytes over a valid/ready handshake and launches each byte into the transmitter with a one-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes. Multi-byte messages are kept contiguous by locking the grant until the requester marks its last byte. The block sits between the command/telemetry sources and the UART transmitter in the tx_clk domain.

## Interface

- NUM_REQ, 4: number of requesters, 2..8.
- BUSY_TIMEOUT, 16: cycles allowed after tx_start for tx_busy to rise, ≥2.
- tx_clk  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on its slice of req_data.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte from requester i is the last of its message.
- req_ready  out  NUM_REQ  combinational one-hot; byte i consumed this cycle when req_valid[i]&req_ready[i].
- tx_data  out  8  byte to transmitter, registered, held stable until frame done.
- tx_start  out  1  one-cycle launch pulse to transmitter, registered.
- tx_busy  in  1  transmitter frame in progress.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently or last granted.
- grant_active  out  1  state≠IDLE or lock held.
- timeout_err  out  1  one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT.
- byte_count  out  16  frames completed since reset, wraps 0xFFFF→0x0000.

## Operation

- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, unlocked: winner = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. req_ready[winner]=1. All other bits are 0.
- IDLE, locked: only lock_id is eligible. req_ready[lock_id]=req_valid[lock_id]. Other requesters wait indefinitely, even while lock_id is not valid.
- On transfer in IDLE:
  - tx_data←byte, tx_start←1, grant_id←winner, rr_ptr←winner.
  - lock←!req_last[winner], lock_id←winner.
  - wd_cnt←0; go to WAIT_BUSY.
- WAIT_BUSY: tx_start returns to 0 after one cycle; req_ready=0.
  - tx_busy=1 → WAIT_DONE.
  - Otherwise wd_cnt++. When wd_cnt reaches BUSY_TIMEOUT-1 with tx_busy still 0: pulse timeout_err, clear lock, go to IDLE. byte_count is not incremented.
- WAIT_DONE: req_ready=0.
  - tx_busy=0 → IDLE, byte_count++ (16-bit wrap).
- req_ready is 0 in every state other than IDLE and whenever RST=1.
- tx_data changes only on a transfer. Its value persists after the frame completes.
- Reset values: state IDLE, tx_data 0x00, tx_start 0, grant_id 0, rr_ptr NUM_REQ-1 (first search starts at requester 0), lock 0, timeout_err 0, byte_count 0.
- Reset mid-frame abandons the sequence immediately. The transmitter is not told; its own reset governs it.

## Timing

- Transfer in cycle N: tx_start=1 and tx_data valid in cycle N+1 only; state WAIT_BUSY from N+1.
- tx_busy sampled high in cycle M → WAIT_DONE from M+1.
- tx_busy sampled low in WAIT_DONE at cycle K → IDLE and byte_count updated at K+1. The next transfer can occur in cycle K+1.
- Minimum spacing between tx_start pulses is 4 cycles: start, busy-seen, done-seen, accept.
- Timeout: with tx_start at N+1 and tx_busy never high, timeout_err pulses at N+BUSY_TIMEOUT and the state is IDLE from N+BUSY_TIMEOUT.
- Simultaneous valid on several requesters: exactly one req_ready bit per cycle, never more.
- req_last applies only to the byte accepted with it. A lone byte with req_last=1 never locks.

## Test plan

- Reset, then req_valid=4'b0001, data 0x55, last=1; transmitter model raises busy 2 cycles after start and holds it 10 cycles → one tx_start, tx_data=0x55, byte_count=1, req_ready[0] high for exactly one cycle.
- All four requesters valid with last=1 continuously → grant order 0,1,2,3,0 and tx_data sequence matches each slice.
- Requester 2 sends 0xA1 (last=0) while requesters 0/1 are valid; requester 2 then drops valid for 20 cycles and sends 0xA2 (last=1) → no other grant until after 0xA2; next grant goes to requester 3 if valid, else wraps to 0.
- Transmitter never raises busy, BUSY_TIMEOUT=16 → timeout_err pulse exactly 16 cycles after the transfer; lock cleared; byte_count unchanged; next requester accepted.
- RST asserted during WAIT_DONE → next cycle tx_start=0, req_ready=0, grant_active=0, byte_count=0; the first grant after reset goes to requester 0.
- byte_count preloaded via 65535 completed frames, then one more → byte_count=0x0000.
